// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, immediate formats and operand-use helpers for decode_issue_stage
package decode_pkg;

    localparam int DEF_XLEN = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        return (op == OPC_LOAD || op == OPC_OP_IMM || op == OPC_JALR) ? IMM_I :
               op == OPC_STORE ? IMM_S :
               op == OPC_BRANCH ? IMM_B :
               (op == OPC_LUI || op == OPC_AUIPC) ? IMM_U :
               op == OPC_JAL ? IMM_J : IMM_NONE;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return op == OPC_LOAD || op == OPC_OP_IMM || op == OPC_STORE || op == OPC_OP ||
               op == OPC_BRANCH || op == OPC_JALR;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op == OPC_LOAD || op == OPC_OP_IMM || op == OPC_OP || op == OPC_LUI ||
               op == OPC_AUIPC || op == OPC_JAL || op == OPC_JALR;
    endfunction

endpackage

// File: rtl/reg_file_wt.sv
// reg_file_wt: NREG x XLEN register file, 2 read / 1 write, write-through, x0 reads zero
//   CLK, RESET_N (sync, active-low, clears all entries)
//   WEN/WADDR/WDATA write port; RADDR1/RDATA1, RADDR2/RDATA2 read ports
module reg_file_wt
    import decode_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            WEN,
    input  logic [AW-1:0]   WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic [AW-1:0]   RADDR1,
    output logic [XLEN-1:0] RDATA1,
    input  logic [AW-1:0]   RADDR2,
    output logic [XLEN-1:0] RDATA2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        else if (WEN && WADDR != '0)
            mem[WADDR] <= WDATA;
    end

    assign RDATA1 = RADDR1 == '0 ? '0 : (WEN && WADDR == RADDR1) ? WDATA : mem[RADDR1];
    assign RDATA2 = RADDR2 == '0 ? '0 : (WEN && WADDR == RADDR2) ? WDATA : mem[RADDR2];

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I/RV64I decode with scoreboard hazards and a registered valid/ready issue slot
//   CLK, RESET_N (sync, active-low)
//   DE_V/DE_IR/DE_PC/DE_READY fetch side; V_DE_FE_BR_STALL control-flow stall to fetch; FLUSH kills the slot
//   EXE_V/EXE_READY plus EXE_IR/PC/ALU1/ALU2/TARGET/MEM_ADDR/DR/WEN issue slot
//   WB_WEN/WB_DR/WB_DATA retirement write
//   EXE_FWD_*, MEM_FWD_* result buses, used only when DECODE_FWD_EN is defined
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = 32,
    parameter int SB_W = 2
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            DE_V,
    input  logic [31:0]     DE_IR,
    input  logic [XLEN-1:0] DE_PC,
    output logic            DE_READY,
    output logic            V_DE_FE_BR_STALL,
    input  logic            FLUSH,
    output logic            EXE_V,
    input  logic            EXE_READY,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_PC,
    output logic [XLEN-1:0] EXE_ALU1,
    output logic [XLEN-1:0] EXE_ALU2,
    output logic [XLEN-1:0] EXE_TARGET,
    output logic [XLEN-1:0] EXE_MEM_ADDR,
    output logic [4:0]      EXE_DR,
    output logic            EXE_WEN,
    input  logic            WB_WEN,
    input  logic [4:0]      WB_DR,
    input  logic [XLEN-1:0] WB_DATA,
    input  logic            EXE_FWD_V,
    input  logic [4:0]      EXE_FWD_DR,
    input  logic [XLEN-1:0] EXE_FWD_DATA,
    input  logic            EXE_FWD_LOAD,
    input  logic            MEM_FWD_V,
    input  logic [4:0]      MEM_FWD_DR,
    input  logic [XLEN-1:0] MEM_FWD_DATA
);

    localparam int AW = $clog2(NREG);
    localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);
    localparam logic [SB_W-1:0] SB_MAX = '1;
    localparam logic [SB_W-1:0] SB_NEAR = SB_MAX - SB_ONE;

    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rf1, rf2, src1, src2, imm, sum, alu1_d, alu2_d, tgt_d, mem_d;
    logic signed [31:0] imm32;
    imm_fmt_e fmt;
    logic [SB_W-1:0] sb [NREG];
    logic [NREG-1:0] inc_v, dec_v;
    logic use1, use2, hit1, hit2, haz1, haz2, wen_d, rd_sat, hazard, accept, issue;
    logic is_ld, is_st, is_imm, is_br, is_lui, is_aui, is_jal, is_jalr;

    assign op  = DE_IR[6:0];
    assign rd  = DE_IR[11:7];
    assign rs1 = DE_IR[19:15];
    assign rs2 = DE_IR[24:20];

    reg_file_wt #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .CLK(CLK), .RESET_N(RESET_N),
        .WEN(WB_WEN), .WADDR(WB_DR[AW-1:0]), .WDATA(WB_DATA),
        .RADDR1(rs1[AW-1:0]), .RDATA1(rf1),
        .RADDR2(rs2[AW-1:0]), .RDATA2(rf2)
    );

    assign fmt = imm_fmt(op);
    assign imm32 = fmt == IMM_I ? {{20{DE_IR[31]}}, DE_IR[31:20]} :
                   fmt == IMM_S ? {{20{DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]} :
                   fmt == IMM_B ? {{20{DE_IR[31]}}, DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0} :
                   fmt == IMM_U ? {DE_IR[31:12], 12'b0} :
                   fmt == IMM_J ? {{12{DE_IR[31]}}, DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0} : '0;
    assign imm = XLEN'(imm32);

    assign use1 = uses_rs1(op) && rs1 != '0;
    assign use2 = uses_rs2(op) && rs2 != '0;
    assign hit1 = EXE_V && EXE_WEN && EXE_DR == rs1;
    assign hit2 = EXE_V && EXE_WEN && EXE_DR == rs2;

`ifdef DECODE_FWD_EN
    assign src1 = (EXE_FWD_V && EXE_FWD_DR == rs1 && rs1 != '0) ? EXE_FWD_DATA :
                  (MEM_FWD_V && MEM_FWD_DR == rs1 && rs1 != '0) ? MEM_FWD_DATA : rf1;
    assign src2 = (EXE_FWD_V && EXE_FWD_DR == rs2 && rs2 != '0) ? EXE_FWD_DATA :
                  (MEM_FWD_V && MEM_FWD_DR == rs2 && rs2 != '0) ? MEM_FWD_DATA : rf2;
    assign haz1 = use1 && (hit1 || (EXE_FWD_V && EXE_FWD_LOAD && EXE_FWD_DR == rs1));
    assign haz2 = use2 && (hit2 || (EXE_FWD_V && EXE_FWD_LOAD && EXE_FWD_DR == rs2));
`else
    logic unused_fwd;
    assign unused_fwd = ^{EXE_FWD_V, EXE_FWD_DR, EXE_FWD_DATA, EXE_FWD_LOAD,
                          MEM_FWD_V, MEM_FWD_DR, MEM_FWD_DATA};
    assign src1 = rf1;
    assign src2 = rf2;
    // A last pending writer retiring this very cycle is served by register-file write-through
    assign haz1 = use1 && (hit1 || (sb[rs1] != '0 && !(sb[rs1] == SB_ONE && WB_WEN && WB_DR == rs1)));
    assign haz2 = use2 && (hit2 || (sb[rs2] != '0 && !(sb[rs2] == SB_ONE && WB_WEN && WB_DR == rs2)));
`endif

    // The writer still sitting in the slot will bump the counter on issue, so count it too
    assign wen_d  = writes_rd(op) && rd != '0;
    assign rd_sat = wen_d && (sb[rd] == SB_MAX || (sb[rd] == SB_NEAR && EXE_V && EXE_WEN && EXE_DR == rd));
    assign hazard = DE_V && (haz1 || haz2 || rd_sat);

    assign DE_READY = RESET_N && !FLUSH && (!EXE_V || EXE_READY) && !hazard;
    assign accept   = DE_V && DE_READY;
    // A flushed slot is discarded, so it never counts as a pending writer
    assign issue    = EXE_V && EXE_READY && !FLUSH;
    assign V_DE_FE_BR_STALL = DE_V && (op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR);

    assign is_ld   = op == OPC_LOAD;
    assign is_st   = op == OPC_STORE;
    assign is_imm  = op == OPC_OP_IMM;
    assign is_br   = op == OPC_BRANCH;
    assign is_lui  = op == OPC_LUI;
    assign is_aui  = op == OPC_AUIPC;
    assign is_jal  = op == OPC_JAL;
    assign is_jalr = op == OPC_JALR;

    assign sum    = src1 + imm;
    assign alu1_d = is_lui ? imm : (is_aui || is_jal || is_jalr) ? DE_PC : uses_rs1(op) ? src1 : '0;
    assign alu2_d = (is_ld || is_imm || is_aui) ? imm : uses_rs2(op) ? src2 :
                    (is_jal || is_jalr) ? XLEN'(4) : '0;
    assign mem_d  = (is_ld || is_st) ? sum : '0;
    assign tgt_d  = (is_br || is_jal) ? DE_PC + imm : is_jalr ? (sum & ~XLEN'(1)) : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            EXE_V        <= 1'b0;
            EXE_IR       <= '0;
            EXE_PC       <= '0;
            EXE_ALU1     <= '0;
            EXE_ALU2     <= '0;
            EXE_TARGET   <= '0;
            EXE_MEM_ADDR <= '0;
            EXE_DR       <= '0;
            EXE_WEN      <= 1'b0;
        end else if (accept) begin
            EXE_V        <= 1'b1;
            EXE_IR       <= DE_IR;
            EXE_PC       <= DE_PC;
            EXE_ALU1     <= alu1_d;
            EXE_ALU2     <= alu2_d;
            EXE_TARGET   <= tgt_d;
            EXE_MEM_ADDR <= mem_d;
            EXE_DR       <= rd;
            EXE_WEN      <= wen_d;
        end else if (FLUSH || EXE_READY) begin
            EXE_V        <= 1'b0;
        end
    end

    assign inc_v = NREG'(issue && EXE_WEN) << EXE_DR;
    assign dec_v = NREG'(WB_WEN && WB_DR != '0) << WB_DR;

    // Decrement at zero is dropped so writebacks that outlive a reset cannot underflow
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREG; i++) begin
            if (!RESET_N)
                sb[i] <= '0;
            else if (inc_v[i] && !dec_v[i])
                sb[i] <= sb[i] + SB_ONE;
            else if (dec_v[i] && !inc_v[i] && sb[i] != '0)
                sb[i] <= sb[i] - SB_ONE;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed checks of decode_issue_stage (XLEN=64 and XLEN=32 instances)
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, de_v, flush, exe_ready, wb_wen;
    logic [31:0] de_ir;
    logic [63:0] de_pc, wb_data;
    logic [4:0]  wb_dr;
    logic        fwd_v = 1'b0, fwd_ld = 1'b0, mfwd_v = 1'b0;
    logic [4:0]  fwd_dr = '0, mfwd_dr = '0;
    logic [63:0] fwd_data = '0, mfwd_data = '0;

    logic        e_ready, e_stall, e_v, e_wen;
    logic [31:0] e_ir;
    logic [63:0] e_pc, e_alu1, e_alu2, e_tgt, e_mem;
    logic [4:0]  e_dr;

    logic        h_ready, h_stall, h_v, h_wen;
    logic [31:0] h_ir, h_pc, h_alu1, h_alu2, h_tgt, h_mem;
    logic [4:0]  h_dr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(64)) dut (
        .CLK(clk), .RESET_N(rst_n), .DE_V(de_v), .DE_IR(de_ir), .DE_PC(de_pc),
        .DE_READY(e_ready), .V_DE_FE_BR_STALL(e_stall), .FLUSH(flush),
        .EXE_V(e_v), .EXE_READY(exe_ready), .EXE_IR(e_ir), .EXE_PC(e_pc),
        .EXE_ALU1(e_alu1), .EXE_ALU2(e_alu2), .EXE_TARGET(e_tgt), .EXE_MEM_ADDR(e_mem),
        .EXE_DR(e_dr), .EXE_WEN(e_wen), .WB_WEN(wb_wen), .WB_DR(wb_dr), .WB_DATA(wb_data),
        .EXE_FWD_V(fwd_v), .EXE_FWD_DR(fwd_dr), .EXE_FWD_DATA(fwd_data), .EXE_FWD_LOAD(fwd_ld),
        .MEM_FWD_V(mfwd_v), .MEM_FWD_DR(mfwd_dr), .MEM_FWD_DATA(mfwd_data)
    );

    decode_issue_stage #(.XLEN(32)) dut32 (
        .CLK(clk), .RESET_N(rst_n), .DE_V(de_v), .DE_IR(de_ir), .DE_PC(de_pc[31:0]),
        .DE_READY(h_ready), .V_DE_FE_BR_STALL(h_stall), .FLUSH(flush),
        .EXE_V(h_v), .EXE_READY(exe_ready), .EXE_IR(h_ir), .EXE_PC(h_pc),
        .EXE_ALU1(h_alu1), .EXE_ALU2(h_alu2), .EXE_TARGET(h_tgt), .EXE_MEM_ADDR(h_mem),
        .EXE_DR(h_dr), .EXE_WEN(h_wen), .WB_WEN(wb_wen), .WB_DR(wb_dr), .WB_DATA(wb_data[31:0]),
        .EXE_FWD_V(fwd_v), .EXE_FWD_DR(fwd_dr), .EXE_FWD_DATA(fwd_data[31:0]), .EXE_FWD_LOAD(fwd_ld),
        .MEM_FWD_V(mfwd_v), .MEM_FWD_DR(mfwd_dr), .MEM_FWD_DATA(mfwd_data[31:0])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; de_v = 1'b0; de_ir = '0; de_pc = '0; flush = 1'b0;
        exe_ready = 1'b0; wb_wen = 1'b0; wb_dr = '0; wb_data = '0;
        step();
        step();
        chk("rst_v", e_v, 0);
        chk("rst_ready", e_ready, 0);
        chk("rst_alu1", e_alu1, 0);
        chk("rst_v32", h_v, 0);

        rst_n = 1'b1; exe_ready = 1'b1;
        de_v = 1'b1; de_ir = 32'h00500093; de_pc = 64'h0;
        #1;
        chk("addi1_ready", e_ready, 1);
        step();
        chk("addi1_v", e_v, 1);
        chk("addi1_alu2", e_alu2, 5);
        chk("addi1_dr", e_dr, 1);
        de_ir = 32'h00700113; de_pc = 64'h4;
        step();
        chk("addi2_v", e_v, 1);
        chk("addi2_alu2", e_alu2, 7);
        chk("addi2_pc", e_pc, 4);

        exe_ready = 1'b0; de_ir = 32'h00900213; de_pc = 64'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", e_ready, 0);
            step();
            chk("stall_ir", e_ir, 32'h00700113);
            chk("stall_alu2", e_alu2, 7);
        end
        exe_ready = 1'b1;
        #1;
        chk("release_ready", e_ready, 1);
        step();
        chk("x4_ir", e_ir, 32'h00900213);
        chk("x4_alu2", e_alu2, 9);

        de_ir = 32'h002081B3; de_pc = 64'hC;
        #1;
        chk("raw_ready_slot", e_ready, 0);
        step();
        chk("raw_slot_empty", e_v, 0);
        wb_wen = 1'b1; wb_dr = 5'd2; wb_data = 64'd7;
        #1;
        chk("raw_ready_x1_busy", e_ready, 0);
        step();
        wb_dr = 5'd1; wb_data = 64'd5;
        #1;
        chk("raw_ready_wb", e_ready, 1);
        step();
        wb_wen = 1'b0;
        chk("add_ir", e_ir, 32'h002081B3);
        chk("add_alu1", e_alu1, 5);
        chk("add_alu2", e_alu2, 7);
        chk("add_wen", e_wen, 1);

        de_ir = 32'h00C12303; de_pc = 64'h10;
        step();
        chk("lw_alu1", e_alu1, 7);
        chk("lw_alu2", e_alu2, 12);
        chk("lw_mem", e_mem, 64'h13);

        de_ir = 32'hFE000CE3; de_pc = 64'h100;
        #1;
        chk("beq_br_stall", e_stall, 1);
        step();
        chk("beq_v", e_v, 1);
        chk("beq_target", e_tgt, 64'hF8);
        chk("beq_target32", h_tgt, 32'hF8);
        chk("beq_wen", e_wen, 0);
        de_v = 1'b0; flush = 1'b1;
        #1;
        chk("flush_ready", e_ready, 0);
        step();
        chk("flush_v", e_v, 0);
        chk("flush_v32", h_v, 0);
        flush = 1'b0;

        de_v = 1'b1; de_ir = 32'h0100006F; de_pc = 64'h200;
        #1;
        chk("jal_br_stall", e_stall, 1);
        step();
        chk("jal_target", e_tgt, 64'h210);
        chk("jal_alu1", e_alu1, 64'h200);
        chk("jal_alu2", e_alu2, 4);
        chk("jal_wen", e_wen, 0);

        de_ir = 32'h800002B7; de_pc = 64'h204;
        step();
        chk("lui_alu1", e_alu1, 64'hFFFF_FFFF_8000_0000);
        chk("lui_alu1_32", h_alu1, 32'h8000_0000);
        chk("lui_alu2", e_alu2, 0);
        chk("lui_dr", e_dr, 5);

        exe_ready = 1'b0; de_ir = 32'h00700113; de_pc = 64'h208;
        step();
        chk("lui_held", e_ir, 32'h800002B7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", e_ready, 0);
        step();
        chk("rst_mid_v", e_v, 0);
        chk("rst_mid_ir", e_ir, 0);
        chk("rst_mid_pc", e_pc, 0);
        chk("rst_mid_alu1", e_alu1, 0);
        chk("rst_mid_v32", h_v, 0);
        chk("rst_mid_alu1_32", h_alu1, 0);

        rst_n = 1'b1; de_v = 1'b0; exe_ready = 1'b1;
        wb_wen = 1'b1; wb_dr = 5'd3; wb_data = 64'h33;
        step();
        wb_wen = 1'b0;
        de_v = 1'b1; de_ir = 32'h00118393; de_pc = 64'h300;
        #1;
        chk("post_rst_ready", e_ready, 1);
        step();
        chk("post_rst_v", e_v, 1);
        chk("post_rst_alu2", e_alu2, 1);
        de_v = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised successor to the in-order decode stage: decodes RV64I/RV32I instructions, reads a write-through register file, and generates ALU operands, branch/jump targets and load/store addresses. Hazards are tracked with a per-register pending-write scoreboard. Results leave through a registered valid/ready output slot, so EXE back-pressure holds decode instead of dropping instructions. The stage sits between fetch and execute; optional operand forwarding is a compile-time feature.

## Interface
- XLEN, 64, datapath width; only 32 or 64 are legal.
- NREG, 32, architectural registers; x0 is hard-wired to zero.
- SB_W, 2, scoreboard counter width; allows up to 2^SB_W-1 writers in flight per register.
- CLK  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- DE_V  in  1  fetch presents an instruction.
- DE_IR  in  32  instruction.
- DE_PC  in  XLEN  address of DE_IR.
- DE_READY  out  1  decode accepts this cycle.
- V_DE_FE_BR_STALL  out  1  DE_V and the opcode is BRANCH, JAL or JALR.
- FLUSH  in  1  EXE redirect; kills the decode slot.
- EXE_V  out  1  output slot valid.
- EXE_READY  in  1  EXE takes the slot.
- EXE_IR  out  32, EXE_PC  out  XLEN, EXE_ALU1  out  XLEN, EXE_ALU2  out  XLEN.
- EXE_TARGET  out  XLEN, EXE_MEM_ADDR  out  XLEN.
- EXE_DR  out  5, EXE_WEN  out  1  destination register and its write enable (0 when rd=x0).
- WB_WEN  in  1, WB_DR  in  5, WB_DATA  in  XLEN  retirement write.
- EXE_FWD_V  in  1, EXE_FWD_DR  in  5, EXE_FWD_DATA  in  XLEN, EXE_FWD_LOAD  in  1  EXE-stage result bus (forwarding build only).
- MEM_FWD_V  in  1, MEM_FWD_DR  in  5, MEM_FWD_DATA  in  XLEN  MEM-stage result bus (forwarding build only).

## Operation
- Accept: DE_V && DE_READY. Issue: EXE_V && EXE_READY.
- DE_READY = !FLUSH && (!EXE_V || EXE_READY) && !hazard.
- Slot: on accept, load all EXE_* fields and set EXE_V=1. On issue without accept, clear EXE_V. If EXE_V && !EXE_READY, hold every field unchanged.
- Decode by opcode (imm sign-extended from bit 31 to XLEN):
  - LOAD and OP-IMM: ALU1=rs1, ALU2=I-imm. For LOAD, MEM_ADDR=rs1+I-imm.
  - STORE: ALU1=rs1, ALU2=rs2, MEM_ADDR=rs1+S-imm.
  - OP: ALU1=rs1, ALU2=rs2.
  - BRANCH: ALU1=rs1, ALU2=rs2, TARGET=PC+B-imm.
  - LUI: ALU1=U-imm, ALU2=0. AUIPC: ALU1=PC, ALU2=U-imm.
  - JAL: ALU1=PC, ALU2=4, TARGET=PC+J-imm.
  - JALR: ALU1=PC, ALU2=4, TARGET=(rs1+I-imm)&~1.
  - Any other opcode: operands 0, WEN=0; the instruction passes through.
- Source use: rs1 is used by all formats except LUI/AUIPC/JAL; rs2 by OP/STORE/BRANCH. An unused source or x0 never causes a hazard.
- Scoreboard: per-register SB_W-bit counter.
  - +1 on issue with EXE_WEN; -1 on WB_WEN with WB_DR≠0. Both on the same register in one cycle: no change.
  - hazard also when the rd counter is saturated.
- Hazard without forwarding: a used source has counter≠0, or it equals EXE_DR while EXE_V&&EXE_WEN. Exception: counter==1 with WB_WEN&&WB_DR==src in the same cycle is no hazard (register-file write-through).
- FLUSH: clears EXE_V and blocks accept that cycle; scoreboard untouched. The slot never incremented it, and nothing older than EXE is younger than the branch.
- Register file: x0 reads 0; a same-cycle WB write to the read address returns WB_DATA.

## Timing
- Decode latency: 1 cycle, DE accept to EXE_V.
- Sustained 1 instruction/cycle with no hazards.
- Reset (RESET_N=0 at edge): EXE_V=0; all EXE_* data=0; scoreboard=0; register file=0; DE_READY=0 while in reset.
- RESET_N asserted mid-stall clears the slot and counters; in-flight writebacks arriving after reset are ignored (counter never underflows; decrement at 0 is suppressed).

## Configuration
- DECODE_FWD_EN defined:
  - Operand priority: EXE_FWD, then MEM_FWD, then register file/WB, each requiring valid && DR match && DR≠0.
  - Hazard only when the source equals EXE_DR with EXE_V&&EXE_WEN (1-cycle bubble), or EXE_FWD_LOAD matches (load-use), or the rd counter is saturated.
- Undefined: forwarding ports are ignored and the scoreboard rule above applies.

## Structure
- decode_pkg: opcode localparams, imm-format enum, XLEN default, source-use function.
- One sub-module: reg_file_wt (NREG×XLEN, 2R/1W, write-through, x0 zero).

## Test plan
- Independent stream ADDI x1,x0,5; ADDI x2,x0,7 with EXE_READY=1 -> EXE_V every cycle, ALU2=5 then 7.
- EXE_READY=0 for 3 cycles with slot full -> DE_READY=0, EXE_* fields stable, no instruction lost.
- ADD x3,x1,x2 right after ADDI x1 (no FWD) -> DE_READY low until WB_WEN x1 cycle, then accept with the correct value.
- Same with DECODE_FWD_EN, EXE_FWD_DR=1, data 0x55 -> exactly 1 bubble, ALU1=0x55.
- BEQ PC=0x100, B-imm=-8 -> TARGET=0xF8, V_DE_FE_BR_STALL=1; FLUSH next cycle -> EXE_V=0.
- XLEN=32 build: LUI x5,0x80000 -> ALU1=0x80000000; RESET_N low mid-stall -> all outputs 0 next edge.
